report_encoder: RTL

REPORT_ENCODER -- requirements
Module: report_encoder

---
 rtl/report_encoder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/report_encoder.sv
// rtl/report_encoder.sv - terminal report (DSR / DECRQM) response byte generator
//
// Turns one report request into an escape-sequence byte stream for the host
// transmitter. All request inputs are captured at acceptance.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only when idle)
//   req_kind[1:0]     0 status, 1 cursor position, 2 DEC mode, 3 ANSI mode
//   req_param[7:0]    mode number for kinds 2/3
//   cursor_row/col    0-based cursor position (reported 1-based, 9-bit)
//   term_mode[5:0]    {origin_mode, auto_wrap, insert_mode, line_feed,
//                      cursor_blinking, cursor_visibility} (origin_mode = MSB)
//   tx_data/valid/ready  response byte stream
//   busy              response in progress
module report_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  input  logic [7:0] req_param,
  input  logic [7:0] cursor_row,
  input  logic [7:0] cursor_col,
  input  logic [5:0] term_mode,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ESC, CSI, PRIV, ARG1, SEMI, ARG2, DOLLAR, FINAL
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_kind;
  logic [8:0] r_arg1;   // first decimal field value
  logic [8:0] r_arg2;   // second field: column, or Ps (0/1/2) for mode queries
  logic [1:0] r_dig;    // digit being emitted: 2 hundreds, 1 tens, 0 ones

  logic       w_accept;
  logic [8:0] w_row1;
  logic [8:0] w_col1;
  logic [1:0] w_ps;
  logic [8:0] w_arg1_in;
  logic [8:0] w_arg2_in;
  logic [8:0] w_val;
  logic [1:0] w_hund;
  logic [6:0] w_rem;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] w_digit;

  // Index of the most significant non-zero digit (0 still gets one digit).
  function automatic logic [1:0] first_idx(input logic [8:0] v);
    if (v >= 9'd100)     return 2'd2;
    else if (v >= 9'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

  assign req_ready = (r_state == IDLE);
  assign busy      = !req_ready;
  assign tx_valid  = (r_state != IDLE);
  assign w_accept  = req_valid && req_ready;

  assign w_row1 = {1'b0, cursor_row} + 9'd1;
  assign w_col1 = {1'b0, cursor_col} + 9'd1;

  // Ps: 1 = set, 2 = reset, 0 = mode not recognised for this query kind.
  always_comb begin
    w_ps = 2'd0;
    if (req_kind == 2'd2) begin
      case (req_param)
        8'd6:    w_ps = term_mode[5] ? 2'd1 : 2'd2;
        8'd7:    w_ps = term_mode[4] ? 2'd1 : 2'd2;
        8'd12:   w_ps = term_mode[1] ? 2'd1 : 2'd2;
        8'd25:   w_ps = term_mode[0] ? 2'd1 : 2'd2;
        default: w_ps = 2'd0;
      endcase
    end else if (req_kind == 2'd3) begin
      case (req_param)
        8'd4:    w_ps = term_mode[3] ? 2'd1 : 2'd2;
        8'd20:   w_ps = term_mode[2] ? 2'd1 : 2'd2;
        default: w_ps = 2'd0;
      endcase
    end
  end

  always_comb begin
    case (req_kind)
      2'd0:    w_arg1_in = 9'd0;
      2'd1:    w_arg1_in = w_row1;
      default: w_arg1_in = {1'b0, req_param};
    endcase
    w_arg2_in = (req_kind == 2'd1) ? w_col1 : {7'd0, w_ps};
  end

  // Decimal digit split of the field currently being emitted.
  assign w_val = (r_state == ARG2) ? r_arg2 : r_arg1;

  always_comb begin
    if (w_val >= 9'd200) begin
      w_hund = 2'd2;
      w_rem  = 7'(w_val - 9'd200);
    end else if (w_val >= 9'd100) begin
      w_hund = 2'd1;
      w_rem  = 7'(w_val - 9'd100);
    end else begin
      w_hund = 2'd0;
      w_rem  = 7'(w_val);
    end
    w_tens = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (w_rem >= 7'(k * 10)) w_tens = 4'(k);
    end
    w_ones = 4'(w_rem - 7'(w_tens) * 7'd10);
    case (r_dig)
      2'd2:    w_digit = {2'b00, w_hund};
      2'd1:    w_digit = w_tens;
      default: w_digit = w_ones;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    tx_data = 8'h00;
    case (r_state)
      IDLE: if (w_accept) w_next = ESC;
      ESC: begin
        tx_data = 8'h1B;
        if (tx_ready) w_next = CSI;
      end
      CSI: begin
        tx_data = 8'h5B;
        if (tx_ready) w_next = (r_kind == 2'd2) ? PRIV : ARG1;
      end
      PRIV: begin
        tx_data = 8'h3F;
        if (tx_ready) w_next = ARG1;
      end
      ARG1: begin
        tx_data = 8'h30 + {4'h0, w_digit};
        if (tx_ready && r_dig == 2'd0) w_next = (r_kind == 2'd0) ? FINAL : SEMI;
      end
      SEMI: begin
        tx_data = 8'h3B;
        if (tx_ready) w_next = ARG2;
      end
      ARG2: begin
        tx_data = 8'h30 + {4'h0, w_digit};
        if (tx_ready && r_dig == 2'd0) w_next = (r_kind == 2'd1) ? FINAL : DOLLAR;
      end
      DOLLAR: begin
        tx_data = 8'h24;
        if (tx_ready) w_next = FINAL;
      end
      FINAL: begin
        tx_data = (r_kind == 2'd0) ? 8'h6E : (r_kind == 2'd1) ? 8'h52 : 8'h79;
        if (tx_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_kind  <= 2'd0;
      r_arg1  <= 9'd0;
      r_arg2  <= 9'd0;
      r_dig   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_kind <= req_kind;
        r_arg1 <= w_arg1_in;
        r_arg2 <= w_arg2_in;
        r_dig  <= first_idx(w_arg1_in);
      end else if (tx_ready) begin
        case (r_state)
          SEMI:       r_dig <= first_idx(r_arg2);
          ARG1, ARG2: if (r_dig != 2'd0) r_dig <= r_dig - 2'd1;
          default:    ;
        endcase
      end
    end
  end

endmodule
